tt_rc_queue_server: RTL and testbench
=====================================

# tt_rc_queue_server

Traffic-class queue server for the frame-scheduling datapath. It sits between the timetable and the round-robin fixed-priority arbiter:
- It translates the timetable count into a per-class remaining-time count.
- It holds a 16-entry cyclic packet-length source.
- It runs a 3-state ready/go handshake with the arbiter, one packet at a time.

One instance serves one traffic class (TT or RC).

## Interface
Parameters:
- P_TYPE, default 2'b01, traffic class served: 2'b00 PCF, 2'b01 TT, 2'b11 RC, 2'b10 BE.
- Q_OFFSET, default 0, starting read index (0..15) of the packet-length queue.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cur_value  in  8  timetable count: cycles remaining in the current window.
- cur_state  in  2  timetable window class, same encoding as P_TYPE.
- ena_n  in  1  arbiter grant, active low.
- bool_ready  out  1  head packet fits in the remaining window and is waiting for a grant.
- bool_go  out  1  packet transmitting, high for exactly pkt_len cycles.
- pkt_len  out  8  length of the head packet in cycles; 0 means empty.

## Operation
- Translator (combinational):
  - cnt = cur_value when cur_state == P_TYPE, else 0.
  - TT and RC instances therefore each see their own window only.
- Queue:
  - 16 fixed entries, LEN[i] = 2 + 2*(i mod 4), giving 2,4,6,8,2,4,...
  - Read pointer ptr resets to Q_OFFSET.
  - pkt_len = LEN[ptr].
  - ptr increments modulo 16 (15 wraps to 0) on the cycle a falling edge of bool_go is detected synchronously (registered bool_go delayed by one cycle).
- Server FSM, states IDLE, READY, GO:
  - IDLE -> READY when pkt_len != 0 and cnt >= pkt_len.
  - READY -> GO when ena_n == 0. On entry, a remaining counter is loaded with pkt_len.
  - READY -> IDLE when cnt < pkt_len; ready is withdrawn if the window closes or shrinks.
  - GO: counter decrements each cycle. GO -> IDLE when the counter equals 1.
  - GO is non-preemptive: ena_n and cnt are ignored while in GO.
- Outputs are registered: bool_ready = (state == READY), bool_go = (state == GO).

## Timing
- Reset value: state IDLE, bool_ready = 0, bool_go = 0, ptr = Q_OFFSET, counter = 0.
- Reset mid-GO aborts the packet without advancing ptr.
- IDLE->READY latency is 1 cycle after the condition holds.
- READY->GO latency is 1 cycle after ena_n samples low.
- bool_go is high for exactly pkt_len consecutive cycles.
- After GO the FSM spends at least one cycle in IDLE, so bool_ready is low for at least one cycle between packets.
- ptr advances one cycle after bool_go falls; the new pkt_len is valid before the next IDLE evaluation.
- Boundary conditions:
  - cnt == pkt_len qualifies as fitting.
  - cnt == 0 never qualifies.
  - ena_n low while in IDLE has no effect.
  - bool_ready and bool_go are never high together.

## Structure
- Shared package: traffic-class encoding constants (PCF, TT, RC, BE), the FSM state enum, and the LEN table function.
- Natural sub-module: pkt_len_queue, containing ptr, the falling-edge detector and the LEN lookup.
- The translator and the FSM stay in the top module.

## Test plan
- Reset, P_TYPE = TT, Q_OFFSET = 0, cur_state = 01, cur_value = 20:
  - bool_ready rises 1 cycle after reset release, with pkt_len = 2.
  - Drive ena_n low: bool_go high for 2 cycles, then pkt_len = 4.
- cur_state = 11 (RC window) with P_TYPE = TT, cur_value = 200 -> bool_ready stays 0.
- P_TYPE = RC, Q_OFFSET = 2 (pkt_len = 6):
  - cur_value = 5 -> no ready.
  - cur_value = 6 -> ready.
- In READY, drop cur_value from 8 to 3 before the grant (pkt_len = 4) -> bool_ready falls next cycle, no go.
- Grant continuously for 17 packets from Q_OFFSET = 0:
  - go lengths follow 2,4,6,8 repeating.
  - ptr wraps from 15 to 0, so the 17th packet is 2.
- Assert rst_n low mid-GO -> bool_go low at the next edge and pkt_len restored to LEN[Q_OFFSET].

Source files
------------

// File: rtl/tt_rc_queue_server_pkg.sv
// Shared definitions for the traffic-class queue server: class encodings,
// server states and the fixed packet-length table.
package tt_rc_queue_server_pkg;

    localparam logic [1:0] CLS_PCF = 2'b00;
    localparam logic [1:0] CLS_TT  = 2'b01;
    localparam logic [1:0] CLS_RC  = 2'b11;
    localparam logic [1:0] CLS_BE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_GO    = 2'd2
    } state_t;

    // Entry i of the cyclic queue holds 2 + 2*(i mod 4) cycles.
    function automatic logic [7:0] len_of(input logic [3:0] idx);
        return 8'd2 + {5'd0, idx[1:0], 1'b0};
    endfunction

endpackage

// File: rtl/tt_rc_queue_server_pkt_len_queue.sv
// Cyclic 16-entry packet-length source; the read pointer steps once per
// completed packet, detected as a falling edge of the registered go flag.
module tt_rc_queue_server_pkt_len_queue
    import tt_rc_queue_server_pkg::*;
#(
    parameter int Q_OFFSET = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    output logic       advance,
    output logic [7:0] pkt_len
);

    logic [3:0] ptr;
    logic       go_d;

    // High for the single cycle after go drops; the server holds off on
    // qualifying a new packet until the pointer has moved.
    assign advance = go_d & ~go;
    assign pkt_len = len_of(ptr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr  <= 4'(Q_OFFSET);
            go_d <= 1'b0;
        end else begin
            go_d <= go;
            if (advance) begin
                ptr <= ptr + 4'd1;
            end
        end
    end

endmodule

// File: rtl/tt_rc_queue_server.sv
// Per-class queue server: filters the timetable count to this class and
// offers one packet at a time to the arbiter with a ready/go exchange.
module tt_rc_queue_server
    import tt_rc_queue_server_pkg::*;
#(
    parameter logic [1:0] P_TYPE   = CLS_TT,
    parameter int         Q_OFFSET = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cur_value,
    input  logic [1:0] cur_state,
    input  logic       ena_n,
    output logic       bool_ready,
    output logic       bool_go,
    output logic [7:0] pkt_len
);

    // Handshake: bool_ready offers the head packet while it fits the window;
    // a low ena_n sampled in READY commits it, and bool_go then stays high
    // for pkt_len cycles regardless of ena_n or the window.
    logic [7:0] cnt;
    logic       advance;
    state_t     state, state_nx;
    logic [7:0] remain, remain_nx;

    assign cnt = (cur_state == P_TYPE) ? cur_value : 8'd0;

    tt_rc_queue_server_pkt_len_queue #(
        .Q_OFFSET(Q_OFFSET)
    ) u_queue (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (bool_go),
        .advance(advance),
        .pkt_len(pkt_len)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            remain <= 8'd0;
        end else begin
            state  <= state_nx;
            remain <= remain_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        remain_nx = remain;
        case (state)
            ST_IDLE: begin
                if (pkt_len != 8'd0 && cnt >= pkt_len && !advance) begin
                    state_nx = ST_READY;
                end
            end
            ST_READY: begin
                if (!ena_n) begin
                    state_nx  = ST_GO;
                    remain_nx = pkt_len;
                end else if (cnt < pkt_len) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_GO: begin
                remain_nx = remain - 8'd1;
                if (remain == 8'd1) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bool_ready = (state == ST_READY);
    assign bool_go    = (state == ST_GO);

endmodule

// File: tb/tb_tt_rc_queue_server.sv
// Bench for tt_rc_queue_server: a TT instance (offset 0) and an RC instance
// (offset 2) share the timetable inputs and are compared to a cycle model.
module tb_tt_rc_queue_server;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cur_value;
    logic [1:0] cur_state;
    logic       ena_tt, ena_rc;
    logic       rdy_tt, go_tt, rdy_rc, go_rc;
    logic [7:0] len_tt, len_rc;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state, index 0 = TT instance, 1 = RC instance
    int m_ptype [2] = '{1, 3};
    int m_qoff  [2] = '{0, 2};
    bit m_ready [2];
    bit m_go    [2];
    bit m_adv   [2];
    int m_left  [2];
    int m_ptr   [2];

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    tt_rc_queue_server #(.P_TYPE(2'b01), .Q_OFFSET(0)) u_tt (
        .clk(clk), .rst_n(rst_n), .cur_value(cur_value), .cur_state(cur_state),
        .ena_n(ena_tt), .bool_ready(rdy_tt), .bool_go(go_tt), .pkt_len(len_tt)
    );

    tt_rc_queue_server #(.P_TYPE(2'b11), .Q_OFFSET(2)) u_rc (
        .clk(clk), .rst_n(rst_n), .cur_value(cur_value), .cur_state(cur_state),
        .ena_n(ena_rc), .bool_ready(rdy_rc), .bool_go(go_rc), .pkt_len(len_rc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input int i);
        return 2 + 2 * (i % 4);
    endfunction

    // Advance the reference by one clock edge given the inputs at that edge.
    task automatic model_step(input int k, input bit rst, input int val, input int st, input bit ena);
        int cnt, pkt, n_left, n_ptr;
        bit n_ready, n_go;
        if (!rst) begin
            m_ready[k] = 0; m_go[k] = 0; m_adv[k] = 0;
            m_left[k] = 0;  m_ptr[k] = m_qoff[k];
            return;
        end
        cnt     = (st == m_ptype[k]) ? val : 0;
        pkt     = len_of(m_ptr[k]);
        n_ready = m_ready[k];
        n_go    = m_go[k];
        n_left  = m_left[k];
        if (m_go[k]) begin
            if (m_left[k] == 1) n_go = 0;
            n_left = m_left[k] - 1;
        end else if (m_ready[k]) begin
            if (!ena) begin
                n_ready = 0; n_go = 1; n_left = pkt;
            end else if (cnt < pkt) begin
                n_ready = 0;
            end
        end else if (cnt >= pkt && !m_adv[k]) begin
            n_ready = 1;
        end
        n_ptr     = m_adv[k] ? (m_ptr[k] + 1) % 16 : m_ptr[k];
        m_adv[k]  = m_go[k] && !n_go;
        m_ready[k] = n_ready;
        m_go[k]   = n_go;
        m_left[k] = n_left;
        m_ptr[k]  = n_ptr;
    endtask

    task automatic compare_all();
        check_val("ready_tt", 32'(rdy_tt), 32'(m_ready[0]));
        check_val("go_tt",    32'(go_tt),  32'(m_go[0]));
        check_val("len_tt",   32'(len_tt), 32'(len_of(m_ptr[0])));
        check_val("ready_rc", 32'(rdy_rc), 32'(m_ready[1]));
        check_val("go_rc",    32'(go_rc),  32'(m_go[1]));
        check_val("len_rc",   32'(len_rc), 32'(len_of(m_ptr[1])));
        check_val("excl_tt",  32'(rdy_tt & go_tt), 32'd0);
        check_val("excl_rc",  32'(rdy_rc & go_rc), 32'd0);
    endtask

    // Drive one cycle of inputs, step the model across the edge, then sample.
    task automatic run_cycle(input bit rst, input int val, input int st, input bit e0, input bit e1);
        rst_n     = rst;
        cur_value = 8'(val);
        cur_state = 2'(st);
        ena_tt    = e0;
        ena_rc    = e1;
        model_step(0, rst, val, st, e0);
        model_step(1, rst, val, st, e1);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int go_cnt, run, runs, budget;
        bit rst_r, e0_r, e1_r;

        // reset, TT window of 20 cycles
        run_cycle(0, 20, 1, 1, 1);
        run_cycle(0, 20, 1, 1, 1);
        run_cycle(1, 20, 1, 1, 1);
        check_val("tt_ready_after_rst", 32'(rdy_tt), 32'd1);
        check_val("tt_first_len", 32'(len_tt), 32'd2);

        // one grant: go lasts 2 cycles and the head becomes 4
        go_cnt = 0;
        run_cycle(1, 20, 1, 0, 1);
        if (go_tt) go_cnt++;
        for (int i = 0; i < 7; i++) begin
            run_cycle(1, 20, 1, 1, 1);
            if (go_tt) go_cnt++;
        end
        check_val("tt_go_cycles", 32'(go_cnt), 32'd2);
        check_val("tt_next_len", 32'(len_tt), 32'd4);
        check_val("tt_ready_len4", 32'(rdy_tt), 32'd1);

        // window shrinks below the head packet before the grant
        run_cycle(1, 8, 1, 1, 1);
        check_val("tt_ready_at_8", 32'(rdy_tt), 32'd1);
        run_cycle(1, 3, 1, 1, 1);
        check_val("tt_withdrawn", 32'(rdy_tt), 32'd0);
        check_val("tt_no_go", 32'(go_tt), 32'd0);

        // RC window: TT must stay quiet, RC (head 6) follows cur_value
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 200, 3, 1, 1);
            check_val("tt_rc_window", 32'(rdy_tt), 32'd0);
        end
        run_cycle(1, 5, 3, 1, 1);
        run_cycle(1, 5, 3, 1, 1);
        check_val("rc_no_fit_5", 32'(rdy_rc), 32'd0);
        run_cycle(1, 6, 3, 1, 1);
        run_cycle(1, 6, 3, 1, 1);
        check_val("rc_fit_6", 32'(rdy_rc), 32'd1);
        check_val("rc_len6", 32'(len_rc), 32'd6);

        // continuous grant for 17 packets starting from pointer 0
        run_cycle(0, 20, 1, 1, 1);
        for (int i = 0; i < 17; i++) exp_q.push_back(32'(len_of(i % 16)));
        run = 0; runs = 0; budget = 0;
        while (runs < 17 && budget < 400) begin
            run_cycle(1, 20, 1, 0, 1);
            budget++;
            if (go_tt) begin
                run++;
            end else if (run > 0) begin
                check_val("go_run_len", 32'(run), exp_q.pop_front());
                runs++;
                run = 0;
            end
        end
        check_val("go_runs_seen", 32'(runs), 32'd17);

        // reset in the middle of a packet
        budget = 0;
        while (!go_tt && budget < 50) begin
            run_cycle(1, 20, 1, 0, 1);
            budget++;
        end
        check_val("go_before_rst", 32'(go_tt), 32'd1);
        run_cycle(0, 20, 1, 0, 1);
        check_val("rst_mid_go", 32'(go_tt), 32'd0);
        check_val("rst_len_tt", 32'(len_tt), 32'd2);
        check_val("rst_len_rc", 32'(len_rc), 32'd6);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst_r = ($urandom_range(0, 99) != 0);
            e0_r  = ($urandom_range(0, 2) != 0);
            e1_r  = ($urandom_range(0, 2) != 0);
            run_cycle(rst_r, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), e0_r, e1_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
